// File: rtl/debounce_pkg.sv
// Shared types and defaults for the input debouncer and its users.
package debounce_pkg;

    // Debounce FSM: two settled levels, each with a pending-qualification twin.
    typedef enum logic [1:0] {
        LOW       = 2'd0,
        LOW_PEND  = 2'd1,
        HIGH      = 2'd2,
        HIGH_PEND = 2'd3
    } debounce_state_t;

    // 1 ms at a 50 MHz clock: a comfortable window for mechanical contacts.
    localparam int DEBOUNCE_DEFAULT_CYCLES = 50000;
    localparam int DEBOUNCE_CNT_WIDTH      = 16;

endpackage : debounce_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Capture the asynchronous bit, then give it a full cycle to settle.
    // NOTE: non-blocking assignments keep this a true two-stage shift; blocking
    // ones would collapse meta and q into a single flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : sync_2ff

// File: rtl/input_debouncer.sv
// Debounces one raw pin: synchronize, then require STABLE_CYCLES consecutive
// samples at the new level before the registered output follows.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEBOUNCE_DEFAULT_CYCLES,
    parameter int CNT_WIDTH     = DEBOUNCE_CNT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic din_raw,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic                 s2;
    debounce_state_t      state, state_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;
    logic                 dout_n, rise_n, fall_n, busy_n;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din_raw),
        .q   (s2)
    );

    // State, counter and all outputs are registered; reset wins over any transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOW;
            cnt   <= '0;
            dout  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            dout  <= dout_n;
            rise  <= rise_n;
            fall  <= fall_n;
            busy  <= busy_n;
        end
    end

    // Next-state logic: any opposite sample during pending restarts qualification.
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would infer a latch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dout_n  = dout;
        rise_n  = 1'b0;
        fall_n  = 1'b0;

        case (state)
            LOW: begin
                if (s2) begin
                    state_n = LOW_PEND;
                    cnt_n   = CNT_ONE;
                end
            end
            LOW_PEND: begin
                if (!s2) begin
                    state_n = LOW;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = HIGH;
                    cnt_n   = '0;
                    dout_n  = 1'b1;
                    rise_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            HIGH: begin
                if (!s2) begin
                    state_n = HIGH_PEND;
                    cnt_n   = CNT_ONE;
                end
            end
            HIGH_PEND: begin
                if (s2) begin
                    state_n = HIGH;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = LOW;
                    cnt_n   = '0;
                    dout_n  = 1'b0;
                    fall_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: begin
                state_n = LOW;
                cnt_n   = '0;
                dout_n  = 1'b0;
            end
        endcase

        busy_n = (state_n == LOW_PEND) || (state_n == HIGH_PEND);
    end

endmodule : input_debouncer

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with STABLE_CYCLES=4, CNT_WIDTH=4.
module tb_input_debouncer;
    import debounce_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    logic din_raw;
    logic dout, rise, fall, busy;

    int checks = 0;
    int passed = 0;

    // Expected {dout, rise, fall, busy} after each edge E0, E1, ...
    localparam logic [3:0] RISE_EXP [8] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001,
                                            4'b0001, 4'b1100, 4'b1000, 4'b1000};
    localparam logic [3:0] FALL_EXP [8] = '{4'b1000, 4'b1000, 4'b1001, 4'b1001,
                                            4'b1001, 4'b0010, 4'b0000, 4'b0000};

    localparam logic       REJ_DIN  [10] = '{1, 1, 0, 1, 1, 0, 0, 0, 0, 0};
    localparam logic       REJ_BUSY [10] = '{0, 0, 1, 1, 0, 1, 1, 0, 0, 0};

    localparam logic       SET_DIN  [14] = '{1, 0, 1, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    localparam logic [3:0] SET_EXP  [14] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000,
                                             4'b0001, 4'b0000, 4'b0001, 4'b0000,
                                             4'b0001, 4'b0001, 4'b0001, 4'b1100,
                                             4'b1000, 4'b1000};

    // Expected outputs after edges R1..R7 following a one-cycle reset.
    localparam logic [3:0] REL_EXP  [7] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001,
                                            4'b0001, 4'b1100, 4'b1000};

    input_debouncer #(
        .STABLE_CYCLES (N),
        .CNT_WIDTH     (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .din_raw (din_raw),
        .dout    (dout),
        .rise    (rise),
        .fall    (fall),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        din_raw = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({dout, rise, fall, busy} !== 4'b0000)
                $display("FAIL reset cyc=%0d got=%b exp=0000", k, {dout, rise, fall, busy});
            else
                passed++;
        end
        din_raw = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({dout, rise, fall, busy} !== 4'b0000 || dut.state !== LOW)
            $display("FAIL reset_release got=%b state=%0d exp=0000 state=0",
                     {dout, rise, fall, busy}, dut.state);
        else
            passed++;
    endtask

    task automatic test_clean_rise();
        din_raw = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if ({dout, rise, fall, busy} !== RISE_EXP[k])
                $display("FAIL clean_rise E%0d got=%b exp=%b", k, {dout, rise, fall, busy}, RISE_EXP[k]);
            else
                passed++;
        end
    endtask

    task automatic test_clean_fall();
        din_raw = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if ({dout, rise, fall, busy} !== FALL_EXP[k])
                $display("FAIL clean_fall E%0d got=%b exp=%b", k, {dout, rise, fall, busy}, FALL_EXP[k]);
            else
                passed++;
        end
    endtask

    task automatic test_bounce_reject();
        for (int k = 0; k < 10; k++) begin
            din_raw = REJ_DIN[k];
            tick();
            checks++;
            if ({dout, rise, fall, busy} !== {3'b000, REJ_BUSY[k]})
                $display("FAIL bounce_reject E%0d got=%b exp=%b", k,
                         {dout, rise, fall, busy}, {3'b000, REJ_BUSY[k]});
            else
                passed++;
        end
        checks++;
        if (dut.state !== LOW)
            $display("FAIL bounce_reject_state got=%0d exp=%0d", dut.state, LOW);
        else
            passed++;
    endtask

    task automatic test_bounce_settle();
        for (int k = 0; k < 14; k++) begin
            din_raw = SET_DIN[k];
            tick();
            checks++;
            if ({dout, rise, fall, busy} !== SET_EXP[k])
                $display("FAIL bounce_settle E%0d got=%b exp=%b", k, {dout, rise, fall, busy}, SET_EXP[k]);
            else
                passed++;
        end
    endtask

    task automatic test_reset_mid_pending();
        din_raw = 1'b1;
        repeat (4) tick();      // E0..E3: now LOW_PEND with cnt=2
        checks++;
        if (busy !== 1'b1 || dut.cnt !== 4'd2)
            $display("FAIL mid_pending_setup busy=%b cnt=%0d exp busy=1 cnt=2", busy, dut.cnt);
        else
            passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (dut.state !== LOW || dut.cnt !== 4'd0 || {dout, rise, fall, busy} !== 4'b0000)
            $display("FAIL mid_pending_reset state=%0d cnt=%0d out=%b exp state=0 cnt=0 out=0000",
                     dut.state, dut.cnt, {dout, rise, fall, busy});
        else
            passed++;
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++;
            if ({dout, rise, fall, busy} !== REL_EXP[k])
                $display("FAIL mid_pending_release R%0d got=%b exp=%b", k + 1,
                         {dout, rise, fall, busy}, REL_EXP[k]);
            else
                passed++;
        end
    endtask

    initial begin
        rst     = 1'b1;
        din_raw = 1'b0;
        test_reset();
        test_clean_rise();
        test_clean_fall();
        test_bounce_reject();
        test_bounce_settle();
        test_clean_fall();
        test_reset_mid_pending();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_input_debouncer
